// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: stalls, bubbles and flushes for the 5-stage core.
// Define HAZARD_PERF_EN to build the saturating performance counters.
module hazard_stall_controller #(
  parameter int MDU_MAX_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic [4:0]  rd_ex,
  input  logic        mem_read_ex,
  input  logic        branch_taken_ex,
  input  logic        mdu_start_ex,
  input  logic        mdu_done,
  input  logic        dmem_req_mem,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_bubble,
  output logic        ex_mem_write,
  output logic        ex_mem_bubble,
  output logic        mem_wb_write,
  output logic        mdu_timeout,
  output logic [1:0]  state_o,
  output logic [31:0] perf_load_stalls,
  output logic [31:0] perf_mdu_stalls,
  output logic [31:0] perf_mem_stalls,
  output logic [31:0] perf_flushes
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_MAX_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             hold;

  assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                    ((rs1_used_id && (rs1_id == rd_ex)) ||
                     (rs2_used_id && (rs2_id == rd_ex)));

  assign state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_write  = 1'b1;
    mdu_timeout   = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold          = rst;
    case (state_q)
      RUN: begin
        if (dmem_req_mem && !dmem_ready) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
          state_d      = MEM_WAIT;
        end else if (mdu_start_ex && !mdu_done) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          state_d       = MDU_BUSY;
          cnt_d         = '0;
        end else if (branch_taken_ex) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      MDU_BUSY: begin
        if (mdu_done) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          mdu_timeout = 1'b1;
          state_d     = RUN;
          cnt_d       = '0;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          cnt_d         = cnt_q + 1'b1;
        end
      end
      default: begin
        hold    = 1'b1;
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    // Reset and corrupt state both present a frozen pipe with NOP in EX
    if (hold) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_write  = 1'b0;
      ex_mem_bubble = 1'b0;
      mem_wb_write  = 1'b0;
      mdu_timeout   = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic ld_inc, mdu_inc, mem_inc, fl_inc;

  // Only a load-use stall bubbles ID/EX while still loading it unflushed
  assign ld_inc  = id_ex_bubble && id_ex_write && !if_id_flush;
  assign mdu_inc = ex_mem_bubble;
  assign mem_inc = !mem_wb_write && !id_ex_bubble;
  assign fl_inc  = if_id_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_load_stalls <= '0;
      perf_mdu_stalls  <= '0;
      perf_mem_stalls  <= '0;
      perf_flushes     <= '0;
    end else begin
      if (ld_inc && (perf_load_stalls != '1))
        perf_load_stalls <= perf_load_stalls + 1'b1;
      if (mdu_inc && (perf_mdu_stalls != '1))
        perf_mdu_stalls <= perf_mdu_stalls + 1'b1;
      if (mem_inc && (perf_mem_stalls != '1))
        perf_mem_stalls <= perf_mem_stalls + 1'b1;
      if (fl_inc && (perf_flushes != '1))
        perf_flushes <= perf_flushes + 1'b1;
    end
  end
`else
  assign perf_load_stalls = '0;
  assign perf_mdu_stalls  = '0;
  assign perf_mem_stalls  = '0;
  assign perf_flushes     = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller.
// Built with MDU_MAX_CYCLES=8 so the watchdog path is short.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        rs1_used_id, rs2_used_id;
  logic        mem_read_ex, branch_taken_ex;
  logic        mdu_start_ex, mdu_done;
  logic        dmem_req_mem, dmem_ready;
  logic        pc_write, if_id_write, if_id_flush;
  logic        id_ex_write, id_ex_bubble;
  logic        ex_mem_write, ex_mem_bubble;
  logic        mem_wb_write, mdu_timeout;
  logic [1:0]  state_o;
  logic [31:0] perf_load_stalls, perf_mdu_stalls;
  logic [31:0] perf_mem_stalls, perf_flushes;
  logic [8:0]  ctl;

  int total = 0;
  int bad   = 0;

  // {pc,ifid_w,ifid_fl,idex_w,idex_bub,exmem_w,exmem_bub,memwb_w,tmo}
  localparam logic [8:0] C_DEF  = 9'b110101010;
  localparam logic [8:0] C_RST  = 9'b000010000;
  localparam logic [8:0] C_LU   = 9'b000111010;
  localparam logic [8:0] C_BR   = 9'b111111010;
  localparam logic [8:0] C_MEMF = 9'b000000000;
  localparam logic [8:0] C_MDU  = 9'b000001110;
  localparam logic [8:0] C_TO   = 9'b110101011;

  always #5 clk = ~clk;

  assign ctl = {pc_write, if_id_write, if_id_flush,
                id_ex_write, id_ex_bubble, ex_mem_write,
                ex_mem_bubble, mem_wb_write, mdu_timeout};

  hazard_stall_controller #(
    .MDU_MAX_CYCLES(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rs1_id(rs1_id),
    .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id),
    .rs2_used_id(rs2_used_id),
    .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex),
    .branch_taken_ex(branch_taken_ex),
    .mdu_start_ex(mdu_start_ex),
    .mdu_done(mdu_done),
    .dmem_req_mem(dmem_req_mem),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble),
    .ex_mem_write(ex_mem_write),
    .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_write(mem_wb_write),
    .mdu_timeout(mdu_timeout),
    .state_o(state_o),
    .perf_load_stalls(perf_load_stalls),
    .perf_mdu_stalls(perf_mdu_stalls),
    .perf_mem_stalls(perf_mem_stalls),
    .perf_flushes(perf_flushes)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    mem_read_ex = 1'b0; branch_taken_ex = 1'b0;
    mdu_start_ex = 1'b0; mdu_done = 1'b0;
    dmem_req_mem = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic load_use_rs2();
    rd_ex = 5'd5; mem_read_ex = 1'b1;
    rs2_id = 5'd5; rs2_used_id = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    idle();
    #3;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_perf_ld", perf_load_stalls, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("run_default", 32'(ctl), 32'(C_DEF));

    // load-use, rs2 path
    load_use_rs2();
    #1;
    chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_state", 32'(state_o), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_ld_one", perf_load_stalls, 32'd1);
`endif
    idle();
    #1;
    chk("lu_release", 32'(ctl), 32'(C_DEF));

    // rs1 path, and non-hazard variants
    rd_ex = 5'd9; mem_read_ex = 1'b1;
    rs1_id = 5'd9; rs1_used_id = 1'b1;
    #1;
    chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    rs1_used_id = 1'b0;
    #1;
    chk("lu_unused_src", 32'(ctl), 32'(C_DEF));
    idle();
    mem_read_ex = 1'b1; rs1_used_id = 1'b1;
    #1;
    chk("lu_rd_x0", 32'(ctl), 32'(C_DEF));
    idle();
    rd_ex = 5'd5; rs2_id = 5'd5; rs2_used_id = 1'b1;
    #1;
    chk("lu_not_load", 32'(ctl), 32'(C_DEF));

    // load-use under a taken branch
    idle();
    load_use_rs2();
    branch_taken_ex = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("br_state", 32'(state_o), 32'd0);
    idle();

    // MDU: start cycle + 4 busy stall cycles, release on done
    mdu_start_ex = 1'b1;
    #1;
    chk("mdu_start_ctl", 32'(ctl), 32'(C_MDU));
    chk("mdu_start_st", 32'(state_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) branch_taken_ex = 1'b1;
      if (i == 2) begin
        branch_taken_ex = 1'b0;
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
      end
      #1;
      chk($sformatf("mdu_busy%0d_ctl", i), 32'(ctl), 32'(C_MDU));
      chk($sformatf("mdu_busy%0d_st", i), 32'(state_o), 32'd2);
    end
    tick();
    dmem_req_mem = 1'b0; dmem_ready = 1'b1;
    mdu_done = 1'b1;
    #1;
    chk("mdu_done_ctl", 32'(ctl), 32'(C_DEF));
    chk("mdu_done_st", 32'(state_o), 32'd2);
    tick();
    idle();
    #1;
    chk("mdu_after_st", 32'(state_o), 32'd0);
    chk("mdu_after_ctl", 32'(ctl), 32'(C_DEF));
`ifdef HAZARD_PERF_EN
    chk("perf_mdu_five", perf_mdu_stalls, 32'd5);
    chk("perf_fl_one", perf_flushes, 32'd1);
`endif

    // start and done together: no stall
    mdu_start_ex = 1'b1; mdu_done = 1'b1;
    #1;
    chk("mdu_same_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    chk("mdu_same_st", 32'(state_o), 32'd0);
    idle();

    // watchdog: 7 busy stall cycles, timeout in the 8th
    mdu_start_ex = 1'b1;
    tick();
    for (int i = 1; i < 8; i++) begin
      #1;
      chk($sformatf("wd_busy%0d", i), 32'(ctl), 32'(C_MDU));
      tick();
    end
    #1;
    chk("wd_timeout_ctl", 32'(ctl), 32'(C_TO));
    chk("wd_timeout_st", 32'(state_o), 32'd2);
    tick();
    mdu_start_ex = 1'b0;
    #1;
    chk("wd_after_st", 32'(state_o), 32'd0);
    chk("wd_after_ctl", 32'(ctl), 32'(C_DEF));

    // mem wait with a pending load-use
    idle();
    load_use_rs2();
    dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("mw0_ctl", 32'(ctl), 32'(C_MEMF));
    chk("mw0_st", 32'(state_o), 32'd0);
    for (int i = 1; i < 3; i++) begin
      tick();
      chk($sformatf("mw%0d_ctl", i), 32'(ctl), 32'(C_MEMF));
      chk($sformatf("mw%0d_st", i), 32'(state_o), 32'd1);
    end
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("mw_rel_ctl", 32'(ctl), 32'(C_DEF));
    chk("mw_rel_st", 32'(state_o), 32'd1);
    tick();
    dmem_req_mem = 1'b0;
    #1;
    chk("mw_lu_ctl", 32'(ctl), 32'(C_LU));
    chk("mw_lu_st", 32'(state_o), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_mem_three", perf_mem_stalls, 32'd3);
`endif

    // async reset in the middle of MDU_BUSY
    idle();
    mdu_start_ex = 1'b1;
    tick();
    tick();
    chk("ar_pre_st", 32'(state_o), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_st", 32'(state_o), 32'd0);
    chk("ar_ctl", 32'(ctl), 32'(C_RST));
    chk("ar_perf_mdu", perf_mdu_stalls, 32'd0);
    chk("ar_perf_ld", perf_load_stalls, 32'd0);
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("ar_release_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    chk("ar_release_st", 32'(state_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
